// File: rtl/proj_sorter_ctrl.sv
// rtl/proj_sorter_ctrl.sv - MinHash top-K sorter sequencing controller
//
// Accepts one hash signature per cycle, tags it with its element index and
// feeds it to the external top-K sorter. At end of document it captures the
// sorter's K smallest indices, returns them downstream and then clears the
// sorter for the next document.
//
// Ports:
//   in_clk, in_rst          clock, synchronous active-high reset
//   in_valid / out_ready    upstream item handshake
//   in_signature, in_last   item signature, end-of-document marker
//   out_srt_signature       signature to sorter (all-ones filler when idle)
//   out_srt_index           index to sorter (0 when idle)
//   out_srt_rst_n           sorter clear, active-low
//   in_srt_smallest_idx     sorter result, slot j at [j*INDICE_LEN +: INDICE_LEN], slot 0 smallest
//   out_valid / in_ready    downstream result handshake
//   out_indices             captured result, same packing as in_srt_smallest_idx
//   out_count               valid slots, min(items, INDICES_COUNT)
//   out_overflow            document exceeded 2^INDICE_LEN items
//
// Build option: define SORTER_CTRL_EMPTY_MASK_EN to write all-ones into
// captured slots that hold no real item (slot index >= out_count).

module proj_sorter_ctrl #(
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 16,
    parameter int SIGNATURE_LEN = 32,
    localparam int COUNT_W      = $clog2(INDICES_COUNT + 1)
) (
    input  logic                                in_clk,
    input  logic                                in_rst,
    input  logic                                in_valid,
    output logic                                out_ready,
    input  logic [SIGNATURE_LEN-1:0]            in_signature,
    input  logic                                in_last,
    output logic [SIGNATURE_LEN-1:0]            out_srt_signature,
    output logic [INDICE_LEN-1:0]               out_srt_index,
    output logic                                out_srt_rst_n,
    input  logic [INDICES_COUNT*INDICE_LEN-1:0] in_srt_smallest_idx,
    output logic                                out_valid,
    input  logic                                in_ready,
    output logic [INDICES_COUNT*INDICE_LEN-1:0] out_indices,
    output logic [COUNT_W-1:0]                  out_count,
    output logic                                out_overflow
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t                              state;
    state_t                              state_next;
    logic                                accept;
    logic [INDICE_LEN-1:0]               idx_cnt;
    logic [COUNT_W-1:0]                  item_cnt;
    logic                                overflow;
    logic [INDICES_COUNT*INDICE_LEN-1:0] cap_indices;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // out_ready and out_valid depend on state only, so there is no
    // combinational path from in_valid or in_ready back to the handshakes.
    always_comb begin
        state_next = state;
        out_ready  = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_CLEAR: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                out_ready = 1'b1;
                accept    = in_valid;
                if (in_valid && in_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last item enters the sorter on the edge into DRAIN;
                // its result is settled and captured on the edge out of it.
                state_next = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (in_ready) begin
                    state_next = ST_CLEAR;
                end
            end
            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // The sorter clears on the same edge as the controller, including while
    // the controller itself is held in reset.
    assign out_srt_rst_n = ~(in_rst | (state == ST_CLEAR));

    // Idle cycles feed an all-ones signature: it never compares smaller than
    // a stored entry, so it cannot displace real items, and empty slots keep
    // their cleared index of 0.
    always_comb begin
        out_srt_signature = accept ? in_signature : '1;
        out_srt_index     = accept ? idx_cnt : '0;
    end

    always_comb begin
        cap_indices = in_srt_smallest_idx;
`ifdef SORTER_CTRL_EMPTY_MASK_EN
        for (int j = 0; j < INDICES_COUNT; j++) begin
            if (COUNT_W'(j) >= item_cnt) begin
                cap_indices[j*INDICE_LEN +: INDICE_LEN] = '1;
            end
        end
`endif
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            idx_cnt      <= '0;
            item_cnt     <= '0;
            overflow     <= 1'b0;
            out_indices  <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                idx_cnt  <= '0;
                item_cnt <= '0;
                overflow <= 1'b0;
            end
            if (accept) begin
                idx_cnt <= idx_cnt + INDICE_LEN'(1);
                if (item_cnt != COUNT_W'(INDICES_COUNT)) begin
                    item_cnt <= item_cnt + COUNT_W'(1);
                end
                // Wrapping is only harmful when another item follows.
                if ((&idx_cnt) && !in_last) begin
                    overflow <= 1'b1;
                end
            end
            if (state == ST_DRAIN) begin
                out_indices  <= cap_indices;
                out_count    <= item_cnt;
                out_overflow <= overflow;
            end
        end
    end

endmodule

// File: tb/tb_proj_sorter_ctrl.sv
// tb/tb_proj_sorter_ctrl.sv - self-checking bench for proj_sorter_ctrl
//
// Two controllers (INDICE_LEN=16 and INDICE_LEN=4) receive identical
// stimulus, each driving its own behavioural top-K sorter model.

module tb_proj_sorter_ctrl;

    localparam int K = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] in_sig;

    logic        a_ready, a_srt_rstn, a_valid, a_ovf;
    logic [31:0] a_srt_sig;
    logic [15:0] a_srt_idx;
    logic [63:0] a_smallest, a_indices;
    logic [2:0]  a_count;

    logic        b_ready, b_srt_rstn, b_valid, b_ovf;
    logic [31:0] b_srt_sig;
    logic [3:0]  b_srt_idx;
    logic [15:0] b_smallest, b_indices;
    logic [2:0]  b_count;

    proj_sorter_ctrl #(.INDICES_COUNT(K), .INDICE_LEN(16), .SIGNATURE_LEN(32)) dut_a (
        .in_clk(clk), .in_rst(rst), .in_valid(in_valid), .out_ready(a_ready),
        .in_signature(in_sig), .in_last(in_last),
        .out_srt_signature(a_srt_sig), .out_srt_index(a_srt_idx), .out_srt_rst_n(a_srt_rstn),
        .in_srt_smallest_idx(a_smallest), .out_valid(a_valid), .in_ready(in_ready),
        .out_indices(a_indices), .out_count(a_count), .out_overflow(a_ovf)
    );

    proj_sorter_ctrl #(.INDICES_COUNT(K), .INDICE_LEN(4), .SIGNATURE_LEN(32)) dut_b (
        .in_clk(clk), .in_rst(rst), .in_valid(in_valid), .out_ready(b_ready),
        .in_signature(in_sig), .in_last(in_last),
        .out_srt_signature(b_srt_sig), .out_srt_index(b_srt_idx), .out_srt_rst_n(b_srt_rstn),
        .in_srt_smallest_idx(b_smallest), .out_valid(b_valid), .in_ready(in_ready),
        .out_indices(b_indices), .out_count(b_count), .out_overflow(b_ovf)
    );

    // Behavioural sorter: ascending list of K {signature, index}; a new entry
    // is inserted only if strictly smaller than an existing one.
    logic [31:0] m_sig [2][K];
    logic [15:0] m_idx [2][K];
    logic [31:0] s_sig [2];
    logic [15:0] s_idx [2];
    logic        s_rstn[2];
    int          pos   [2];

    always_comb begin
        s_sig[0]  = a_srt_sig;
        s_sig[1]  = b_srt_sig;
        s_idx[0]  = a_srt_idx;
        s_idx[1]  = {12'd0, b_srt_idx};
        s_rstn[0] = a_srt_rstn;
        s_rstn[1] = b_srt_rstn;
        for (int u = 0; u < 2; u++) begin
            pos[u] = K;
            for (int j = K - 1; j >= 0; j--) begin
                if (s_sig[u] < m_sig[u][j]) pos[u] = j;
            end
        end
    end

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            for (int j = 0; j < K; j++) begin
                if (!s_rstn[u]) begin
                    m_sig[u][j] <= '1;
                    m_idx[u][j] <= '0;
                end else if (j == pos[u]) begin
                    m_sig[u][j] <= s_sig[u];
                    m_idx[u][j] <= s_idx[u];
                end else if (j > 0 && j > pos[u]) begin
                    m_sig[u][j] <= m_sig[u][j-1];
                    m_idx[u][j] <= m_idx[u][j-1];
                end
            end
        end
    end

    assign a_smallest = {m_idx[0][3], m_idx[0][2], m_idx[0][1], m_idx[0][0]};
    assign b_smallest = {m_idx[1][3][3:0], m_idx[1][2][3:0], m_idx[1][1][3:0], m_idx[1][0][3:0]};

    typedef struct {
        int n;
        int sig[8];
        bit ramp;
        bit bubble;
        int hold;
        int exp[K];
    } doc_t;

    typedef struct {
        logic [63:0] idx16;
        logic [15:0] idx4;
        logic [2:0]  cnt;
        logic        ovf4;
    } sb_t;

    sb_t sbq[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic sb_t make_exp(input doc_t d);
        sb_t r;
        int  c;
        c = (d.n < K) ? d.n : K;
        r.cnt  = 3'(c);
        r.ovf4 = (d.n > 16);
        for (int j = 0; j < K; j++) begin
            r.idx16[j*16 +: 16] = 16'(d.exp[j]);
            r.idx4[j*4 +: 4]    = 4'(d.exp[j]);
`ifdef SORTER_CTRL_EMPTY_MASK_EN
            if (j >= c) begin
                r.idx16[j*16 +: 16] = '1;
                r.idx4[j*4 +: 4]    = '1;
            end
`endif
        end
        return r;
    endfunction

    // Scoreboard consumer: compare on every result handshake.
    always @(negedge clk) begin
        if (!rst && a_valid && in_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 1'b1, 1'b0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("a_indices", a_indices, e.idx16);
                chk("a_count", a_count, e.cnt);
                chk("a_overflow", a_ovf, 1'b0);
                chk("b_valid", b_valid, 1'b1);
                chk("b_indices", b_indices, e.idx4);
                chk("b_count", b_count, e.cnt);
                chk("b_overflow", b_ovf, e.ovf4);
            end
        end
    end

    task automatic run_doc(input doc_t d);
        int   i;
        int   guard;
        bit   tog;
        logic rdy;
        sb_t  e;
        e = make_exp(d);
        sbq.push_back(e);
        i = 0; guard = 0; tog = 1'b0;
        while (i < d.n && guard < 400) begin
            guard++;
            in_valid = !(d.bubble && tog);
            tog      = ~tog;
            in_sig   = d.ramp ? 32'(200 - i) : 32'(d.sig[i]);
            in_last  = (i == d.n - 1);
            rdy      = a_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) i++;
        end
        chk("doc_accepted", 64'(i), 64'(d.n));
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("drain_valid", {b_valid, a_valid}, 2'b00);
        chk("drain_ready", {b_ready, a_ready}, 2'b00);
        in_ready = (d.hold == 0);
        @(posedge clk); #1;
        chk("out_valid_latency", {b_valid, a_valid}, 2'b11);
        for (int h = 0; h < d.hold; h++) begin
            chk("hold_valid", a_valid, 1'b1);
            chk("hold_ready", a_ready, 1'b0);
            chk("hold_indices", a_indices, e.idx16);
            chk("hold_count", a_count, e.cnt);
            @(posedge clk); #1;
        end
        in_ready = 1'b1;
        @(posedge clk); #1;
        chk("clear_valid", a_valid, 1'b0);
        chk("clear_ready", a_ready, 1'b0);
        chk("clear_srt_rstn", {b_srt_rstn, a_srt_rstn}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    doc_t tbl[6];
    doc_t hd;

    initial begin
        tbl[0] = '{6,  '{50, 10, 40, 30, 20, 60, 0, 0}, 1'b0, 1'b0, 0, '{1, 4, 3, 2}};
        tbl[1] = '{2,  '{7, 3, 0, 0, 0, 0, 0, 0},       1'b0, 1'b0, 0, '{1, 0, 0, 0}};
        tbl[2] = '{6,  '{50, 10, 40, 30, 20, 60, 0, 0}, 1'b0, 1'b1, 5, '{1, 4, 3, 2}};
        tbl[3] = '{2,  '{100, 90, 0, 0, 0, 0, 0, 0},    1'b0, 1'b0, 0, '{1, 0, 0, 0}};
        tbl[4] = '{17, '{0, 0, 0, 0, 0, 0, 0, 0},       1'b1, 1'b0, 0, '{16, 15, 14, 13}};
        tbl[5] = '{3,  '{8, 2, 6, 0, 0, 0, 0, 0},       1'b0, 1'b0, 0, '{1, 2, 0, 0}};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_ready = 1'b1;
        in_sig   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {b_valid, a_valid}, 2'b00);
        chk("rst_ready", {b_ready, a_ready}, 2'b00);
        chk("rst_srt_rstn", {b_srt_rstn, a_srt_rstn}, 2'b00);
        chk("rst_indices", a_indices, 64'd0);
        chk("rst_count_ovf", {b_count, a_count, b_ovf, a_ovf}, 8'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_clear_ready", a_ready, 1'b0);
        chk("post_rst_clear_srt_rstn", a_srt_rstn, 1'b0);
        @(posedge clk); #1;
        chk("post_rst_run_ready", {b_ready, a_ready}, 2'b11);
        chk("post_rst_run_srt_rstn", a_srt_rstn, 1'b1);

        for (int t = 0; t < 6; t++) begin
            run_doc(tbl[t]);
        end

        // Reset in the middle of a document drops it entirely.
        @(posedge clk); #1;
        chk("mid_run_ready", a_ready, 1'b1);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_sig = 32'(1 + k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("mid_rst_srt_rstn", a_srt_rstn, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_clear_ready", a_ready, 1'b0);
        chk("mid_rst_valid", a_valid, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("mid_rst_no_valid", {b_valid, a_valid}, 2'b00);
        end

        hd = '{2, '{5, 9, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 0, '{0, 1, 0, 0}};
        run_doc(hd);
        hd = '{1, '{42, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 0, '{0, 0, 0, 0}};
        run_doc(hd);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
